counter_timer_ctrl: RTL

Sequencing controller for an 8-bit up counter datapath: captures a start value, a compare value and a prescale value, then steps the counter at a programmable rate until it hits the compare value. Supports one-shot and auto-reload modes, hold (pause) and stop. Sits between button/register-level control inputs and the counter core; it drives the core's load and enable.

---
 rtl/counter_ctrl_pkg.sv | 18 +
 rtl/up_counter_core.sv | 41 ++++
 rtl/counter_timer_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter/timer sequencing controller:
// FSM state encoding, mode encodings and default widths.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 8;
    localparam int PERIODS_W          = 8;

endpackage : counter_ctrl_pkg

// File: rtl/up_counter_core.sv
// WIDTH-bit up counter with synchronous load (takes priority over enable),
// count enable and natural modulo-2^WIDTH wrap.
module up_counter_core
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_btn_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: load wins, otherwise step by one when enabled
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : up_counter_core

// File: rtl/counter_timer_ctrl.sv
// Sequencing controller for an up counter: captures start/compare/prescale
// settings, steps the counter core every prescale+1 cycles until the compare
// value, in one-shot or auto-reload mode, with hold and stop.
// Optional completed-period counter enabled by COUNTER_TIMER_CTRL_PERIOD_CNT_EN.
module counter_timer_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset_btn_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [WIDTH-1:0]      compare_value,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [PERIODS_W-1:0]  periods
);

    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      load_sh_q, load_sh_d;
    logic [WIDTH-1:0]      cmp_sh_q, cmp_sh_d;
    logic                  mode_sh_q, mode_sh_d;
    logic [PRESCALE_W-1:0] pre_sh_q, pre_sh_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic capture;
    logic tick;
    logic at_cmp;
    logic core_load;
    logic core_en;

    // Settings are latched only when a run is actually launched from IDLE
    assign capture = (state_q == IDLE) && start && !stop;
    // hold suppresses the tick, so a frozen RUN never reaches terminal
    assign tick    = (state_q == RUN) && !hold && (presc_q == pre_sh_q);
    assign at_cmp  = (count == cmp_sh_q);

    // FSM state register
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; stop always returns to IDLE ahead of any tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick && at_cmp && (mode_sh_q == MODE_ONESHOT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: core controls, prescaler, shadow capture, done/busy
    always_comb begin
        core_load = 1'b0;
        core_en   = 1'b0;
        done_d    = 1'b0;
        presc_d   = presc_q;
        load_sh_d = load_sh_q;
        cmp_sh_d  = cmp_sh_q;
        mode_sh_d = mode_sh_q;
        pre_sh_d  = pre_sh_q;
        busy_d    = (state_d != IDLE);

        if (capture) begin
            load_sh_d = load_value;
            cmp_sh_d  = compare_value;
            mode_sh_d = mode;
            pre_sh_d  = prescale;
        end

        if (state_q == LOAD) begin
            presc_d = '0;
            if (!stop) begin
                core_load = 1'b1;
            end
        end

        if ((state_q == RUN) && !stop && !hold) begin
            if (tick) begin
                presc_d = '0;
                if (at_cmp) begin
                    done_d = 1'b1;
                    if (mode_sh_q == MODE_RELOAD) begin
                        core_load = 1'b1;
                    end
                end else begin
                    core_en = 1'b1;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // Prescaler, shadow settings and registered status outputs
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            presc_q   <= '0;
            load_sh_q <= '0;
            cmp_sh_q  <= '0;
            mode_sh_q <= MODE_ONESHOT;
            pre_sh_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            load_sh_q <= load_sh_d;
            cmp_sh_q  <= cmp_sh_d;
            mode_sh_q <= mode_sh_d;
            pre_sh_q  <= pre_sh_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    up_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_btn_n (reset_btn_n),
        .load        (core_load),
        .en          (core_en),
        .load_value  (load_sh_q),
        .count       (count)
    );

    assign busy = busy_q;
    assign done = done_q;

`ifdef COUNTER_TIMER_CTRL_PERIOD_CNT_EN
    logic [PERIODS_W-1:0] periods_q, periods_d;

    // Saturating count of completed periods, cleared when a new run launches
    always_comb begin
        periods_d = periods_q;
        if (capture) begin
            periods_d = '0;
        end else if (done_d && (periods_q != {PERIODS_W{1'b1}})) begin
            periods_d = periods_q + PERIODS_W'(1);
        end
    end

    // Period counter register
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            periods_q <= '0;
        end else begin
            periods_q <= periods_d;
        end
    end

    assign periods = periods_q;
`else
    assign periods = '0;
`endif

endmodule : counter_timer_ctrl
